vram_write_buffer: RTL

//   Upstream feeder of the foreground/background stages' VRAM write ports
//   (data, address). Queues CPU writes to VRAM in a FIFO at any time.

---
 rtl/vram_write_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/vram_write_buffer.sv
// rtl/vram_write_buffer.sv - CPU-to-VRAM write FIFO gated by the video timing writable window
//
// Purpose:
//   Queues CPU writes to VRAM at any time and replays them, in order, to the
//   foreground/background memories only in cycles where the timing generator
//   says VRAM may be written. Flags dropped writes and pulses when a drain
//   empties the queue.
//
// Ports:
//   clk           pixel clock
//   rst           asynchronous reset, active-low
//   writable      VRAM may be written this cycle (from video timing)
//   cpu_wr_en     CPU write request
//   cpu_addr      CPU target VRAM address
//   cpu_data      CPU write data
//   cpu_ready     queue can accept a write this cycle
//   overflow      sticky: a write arrived while cpu_ready was low
//   overflow_clr  clears overflow (a same-edge set takes priority)
//   vram_we       write strobe to VRAM consumers
//   address       VRAM address presented to consumers
//   data          VRAM data presented to consumers
//   count         entries currently queued
//   drain_done    one-cycle pulse after a pop empties the queue

`ifndef VRAM_ADDR_WIDTH
`define VRAM_ADDR_WIDTH 16
`endif

module vram_write_buffer #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = `VRAM_ADDR_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       writable,
   input  logic                       cpu_wr_en,
   input  logic [ADDR_W-1:0]          cpu_addr,
   input  logic [7:0]                 cpu_data,
   output logic                       cpu_ready,
   output logic                       overflow,
   input  logic                       overflow_clr,
   output logic                       vram_we,
   output logic [ADDR_W-1:0]          address,
   output logic [7:0]                 data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       drain_done
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + 8;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [ENT_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]  head;
   logic [PTR_W-1:0]  tail;
   logic [ENT_W-1:0]  last_entry;
   logic [ENT_W-1:0]  head_entry;
   logic              not_empty;
   logic              push;
   logic              pop;

   assign not_empty  = (count != '0);
   assign cpu_ready  = (count != FULL);
   assign push       = cpu_wr_en & cpu_ready;
   // writable only reaches the outside world through this gate, so a strobe
   // can never appear during active video.
   assign vram_we    = writable & not_empty;
   assign pop        = vram_we;
   assign head_entry = mem[head];

   // Fall-through: show the head entry while one exists, otherwise keep
   // showing whatever was last presented (zero out of reset).
   assign address = not_empty ? head_entry[ENT_W-1:8] : last_entry[ENT_W-1:8];
   assign data    = not_empty ? head_entry[7:0]       : last_entry[7:0];

   // Storage carries no reset; count gates every read of it.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= {cpu_addr, cpu_data};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         last_entry <= '0;
         overflow   <= 1'b0;
         drain_done <= 1'b0;
      end else begin
         if (push) begin
            tail <= tail + PTR_W'(1);
         end
         if (pop) begin
            head <= head + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + ONE;
         end else if (pop && !push) begin
            count <= count - ONE;
         end
         if (not_empty) begin
            last_entry <= head_entry;
         end
         if (cpu_wr_en && !cpu_ready) begin
            overflow <= 1'b1;
         end else if (overflow_clr) begin
            overflow <= 1'b0;
         end
         drain_done <= pop & ~push & (count == ONE);
      end
   end

endmodule
